// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling, one-cycle valid / frame_err strobes.
// Optional: define UART_RX_MAJORITY_EN for 2-of-3 voting around each bit centre.
module uart_rx #(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;

`ifdef UART_RX_MAJORITY_EN
   // Decision lands one count after the centre; restarting at 1 keeps the bit period exact.
   localparam int CW        = $clog2(CLKS_PER_BIT + 1);
   localparam int START_DEC = HALF_BIT;
   localparam int BIT_DEC   = CLKS_PER_BIT;
   localparam int CNT_RST   = 1;
`else
   localparam int CW        = $clog2(CLKS_PER_BIT);
   localparam int START_DEC = HALF_BIT - 1;
   localparam int BIT_DEC   = CLKS_PER_BIT - 1;
   localparam int CNT_RST   = 0;
`endif

   localparam logic [CW-1:0] START_DEC_C = CW'(START_DEC);
   localparam logic [CW-1:0] BIT_DEC_C   = CW'(BIT_DEC);
   localparam logic [CW-1:0] CNT_RST_C   = CW'(CNT_RST);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shreg_q, shreg_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            frame_err_q, frame_err_d;
   logic            busy_q, busy_d;
   logic            wait_high_q, wait_high_d;
   logic            rx_meta_q, rx_s_q;
   logic            bit_val;

`ifdef UART_RX_MAJORITY_EN
   // vote_q[0] = rx_s one cycle ago, vote_q[1] = two cycles ago
   logic [1:0] vote_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) vote_q <= 2'b11;
      else       vote_q <= {vote_q[0], rx_s_q};
   end

   assign bit_val = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_s_q) | (vote_q[0] & rx_s_q);
`else
   assign bit_val = rx_s_q;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      busy_d      = busy_q;
      wait_high_d = wait_high_q;
      case (state_q)
         IDLE: begin
            // After a break the line must return high before a new start edge counts.
            if (wait_high_q) begin
               if (rx_s_q) wait_high_d = 1'b0;
            end else if (!rx_s_q) begin
               state_d = START;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         START: begin
            if (cnt_q == START_DEC_C) begin
               if (!bit_val) begin
                  state_d   = DATA;
                  bit_idx_d = 3'd0;
                  cnt_d     = CNT_RST_C;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == BIT_DEC_C) begin
               shreg_d[bit_idx_q] = bit_val;
               cnt_d              = CNT_RST_C;
               if (bit_idx_q == 3'd7) state_d   = STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == BIT_DEC_C) begin
               if (bit_val) begin
                  data_d  = shreg_q;
                  valid_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
                  wait_high_d = 1'b1;
               end
               state_d = IDLE;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= 3'd0;
         shreg_q     <= 8'h00;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
         wait_high_q <= 1'b0;
      end else begin
         rx_meta_q   <= rx;
         rx_s_q      <= rx_meta_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
         wait_high_q <= wait_high_d;
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; expected values are hand-computed.
module tb_uart_rx;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   int n_checks = 0;
   int n_fails  = 0;

   int   valid_cnt = 0;
   int   fe_cnt    = 0;
   int   both_cnt  = 0;
   logic busy_seen = 1'b0;
   logic [7:0] last_data = 8'h00;
   logic [7:0] prev_data = 8'h00;
   time  t_start = 0;
   time  t_valid = 0;

   uart_rx #(.CLK_FREQ(1600), .BAUD(100)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (valid) begin
         valid_cnt <= valid_cnt + 1;
         prev_data <= last_data;
         last_data <= data;
         t_valid   <= $time;
      end
      if (frame_err)          fe_cnt   <= fe_cnt + 1;
      if (valid && frame_err) both_cnt <= both_cnt + 1;
      if (busy)               busy_seen <= 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; drives start, 8 data bits LSB first, stop. Optional 1-clk low spike.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int spike_bit);
      rx = 1'b0;
      t_start = $time;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         if (i == spike_bit) begin
            repeat (CPB/2) @(negedge clk);
            rx = 1'b0;
            @(negedge clk);
            rx = b[i];
            repeat (CPB/2 - 1) @(negedge clk);
         end else begin
            repeat (CPB) @(negedge clk);
         end
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
   endtask

   initial begin
      rx    = 1'b1;
      reset = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_data",  32'(data),      32'h00);
      chk("rst_valid", 32'(valid),     32'h0);
      chk("rst_busy",  32'(busy),      32'h0);
      chk("rst_ferr",  32'(frame_err), 32'h0);

      // single frame 0x31
      send_frame(8'h31, 1'b1, -1);
      chk("f31_count", 32'(valid_cnt), 32'd1);
      chk("f31_data",  32'(last_data), 32'h31);
      chk("f31_ferr",  32'(fe_cnt),    32'd0);
      chk("f31_busy",  32'(busy),      32'h0);
`ifdef UART_RX_MAJORITY_EN
      chk("f31_latency", 32'((t_valid - t_start) / 10), 32'd156);
`else
      chk("f31_latency", 32'((t_valid - t_start) / 10), 32'd155);
`endif

      // back-to-back, no idle between stop and next start
      send_frame(8'hA5, 1'b1, -1);
      send_frame(8'h3C, 1'b1, -1);
      chk("b2b_count", 32'(valid_cnt), 32'd3);
      chk("b2b_first", 32'(prev_data), 32'hA5);
      chk("b2b_second",32'(last_data), 32'h3C);
      chk("b2b_ferr",  32'(fe_cnt),    32'd0);

      // short low glitch on idle line
      repeat (CPB) @(negedge clk);
      busy_seen = 1'b0;
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (2*CPB) @(negedge clk);
      chk("glitch_valid", 32'(valid_cnt), 32'd3);
      chk("glitch_ferr",  32'(fe_cnt),    32'd0);
      chk("glitch_busyp", 32'(busy_seen), 32'h1);
      chk("glitch_busy",  32'(busy),      32'h0);

      // bad stop bit, then line held low (break)
      send_frame(8'h55, 1'b0, -1);
      chk("brk_ferr",  32'(fe_cnt),    32'd1);
      chk("brk_valid", 32'(valid_cnt), 32'd3);
      chk("brk_data",  32'(data),      32'h3C);
      busy_seen = 1'b0;
      repeat (3*CPB) @(negedge clk);
      chk("brk_hold_busy", 32'(busy_seen), 32'h0);
      chk("brk_hold_ferr", 32'(fe_cnt),    32'd1);
      rx = 1'b1;
      repeat (2*CPB) @(negedge clk);
      chk("brk_rel_valid", 32'(valid_cnt), 32'd3);
      chk("brk_rel_ferr",  32'(fe_cnt),    32'd1);

      // reset in the middle of bit 4 of a 0xFF frame
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (4*CPB + CPB/2) @(negedge clk);
      chk("mid_busy_pre", 32'(busy), 32'h1);
      reset = 1'b1;
      #1;
      chk("mid_rst_data",  32'(data),      32'h00);
      chk("mid_rst_valid", 32'(valid),     32'h0);
      chk("mid_rst_busy",  32'(busy),      32'h0);
      chk("mid_rst_ferr",  32'(frame_err), 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (4*CPB) @(negedge clk);
      chk("mid_no_valid", 32'(valid_cnt), 32'd3);
      chk("mid_no_ferr",  32'(fe_cnt),    32'd1);

      send_frame(8'h0F, 1'b1, -1);
      chk("f0f_count", 32'(valid_cnt), 32'd4);
      chk("f0f_data",  32'(last_data), 32'h0F);
      chk("f0f_port",  32'(data),      32'h0F);

`ifdef UART_RX_MAJORITY_EN
      send_frame(8'hF3, 1'b1, 4);
      chk("maj_count", 32'(valid_cnt), 32'd5);
      chk("maj_data",  32'(last_data), 32'hF3);
`endif

      chk("never_both", 32'(both_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
